spart_ctrl: RTL and testbench

//  Bus-master sequencer for the spart serial port. Programs the baud divisor

---
 rtl/spart_pkg.sv | 26 ++
 rtl/spart_tx_fifo.sv | 47 ++++
 rtl/spart_ctrl.sv | 153 +++++++++++++++
 tb/tb_spart_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// spart_pkg: shared definitions for the spart bus-master sequencer.
//   ioaddr codes of the spart register map, sequencer state encoding,
//   and default baud divisors for a 50 MHz clock.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;  // TX/RX buffer
  localparam logic [1:0] ADDR_STAT = 2'b01;  // status
  localparam logic [1:0] ADDR_DBL  = 2'b10;  // divisor low byte
  localparam logic [1:0] ADDR_DBH  = 2'b11;  // divisor high byte

  localparam logic [15:0] DEF_DIV0 = 16'd10417;  // 4800 baud
  localparam logic [15:0] DEF_DIV1 = 16'd5208;   // 9600
  localparam logic [15:0] DEF_DIV2 = 16'd2604;   // 19200
  localparam logic [15:0] DEF_DIV3 = 16'd1302;   // 38400

  typedef enum logic [2:0] {
    ST_CFG_LO,
    ST_CFG_HI,
    ST_IDLE,
    ST_RX_READ,
    ST_RX_WAIT,
    ST_TX_WRITE,
    ST_TX_WAIT
  } state_t;

endpackage

// File: rtl/spart_tx_fifo.sv
// spart_tx_fifo: byte FIFO buffering client TX data ahead of the spart.
//   clk, rst   clock, async active-low reset (empties the FIFO)
//   push, din  write request / byte; ignored while full
//   pop        drop the head entry; ignored while empty
//   full/empty occupancy flags from the current pointers
//   head       entry at the read pointer (valid when !empty)
module spart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0] wp, rp;
  logic [7:0]  mem [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spart_ctrl.sv
// spart_ctrl: bus-master sequencer for the spart serial port.
//   Programs the baud divisor after reset and on every br_cfg change, then
//   serves spart RX (rda) ahead of buffered client TX bytes (tbr).
//   clk, rst           clock, async active-low reset
//   br_cfg             baud select (quasi-static)
//   tx_valid/data/rdy  client TX stream into the FIFO
//   rx_valid/rx_data   one-cycle pulse with the byte read from spart
//   cfg_done           divisor programmed
//   iocs/iorw/ioaddr   spart access strobe, direction (1=read), register
//   databus            driven only on write cycles
//   rda, tbr           spart receive-available / transmit-ready
module spart_ctrl
  import spart_pkg::*;
#(
  parameter int          TX_DEPTH = 4,
  parameter logic [15:0] DIV0     = DEF_DIV0,
  parameter logic [15:0] DIV1     = DEF_DIV1,
  parameter logic [15:0] DIV2     = DEF_DIV2,
  parameter logic [15:0] DIV3     = DEF_DIV3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       cfg_done,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr
);

  state_t      state, nxt;
  logic        armed;     // low through reset and the first cycle after release
  logic [1:0]  cur_cfg;
  logic        wait_min;  // TX_WAIT has already spent one cycle
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [7:0]  fifo_head;
  logic [7:0]  wdata;
  logic [15:0] div_new, div_cur;

  function automatic logic [15:0] div_of(input logic [1:0] c);
    case (c)
      2'd0:    div_of = DIV0;
      2'd1:    div_of = DIV1;
      2'd2:    div_of = DIV2;
      default: div_of = DIV3;
    endcase
  endfunction

  // Low byte goes out in the cycle br_cfg is latched, so it uses the live input.
  assign div_new = div_of(br_cfg);
  assign div_cur = div_of(cur_cfg);

  spart_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign tx_ready = !fifo_full;
  assign databus  = (iocs && !iorw) ? wdata : 8'hzz;

  always_comb begin
    nxt      = state;
    iocs     = 1'b0;
    iorw     = 1'b1;
    ioaddr   = ADDR_BUF;
    wdata    = 8'h00;
    fifo_pop = 1'b0;
    if (armed) begin
      case (state)
        ST_CFG_LO: begin
          iocs   = 1'b1;
          iorw   = 1'b0;
          ioaddr = ADDR_DBL;
          wdata  = div_new[7:0];
          nxt    = ST_CFG_HI;
        end
        ST_CFG_HI: begin
          iocs   = 1'b1;
          iorw   = 1'b0;
          ioaddr = ADDR_DBH;
          wdata  = div_cur[15:8];
          nxt    = ST_IDLE;
        end
        ST_IDLE: begin
          if (br_cfg != cur_cfg)       nxt = ST_CFG_LO;
          else if (rda)                nxt = ST_RX_READ;
          else if (!fifo_empty && tbr) nxt = ST_TX_WRITE;
        end
        ST_RX_READ: begin
          iocs = 1'b1;
          nxt  = ST_RX_WAIT;
        end
        ST_RX_WAIT: nxt = ST_IDLE;  // give spart a cycle to drop rda
        ST_TX_WRITE: begin
          iocs     = 1'b1;
          iorw     = 1'b0;
          wdata    = fifo_head;
          fifo_pop = 1'b1;
          nxt      = ST_TX_WAIT;
        end
        ST_TX_WAIT: begin
          // tbr lags the write, so ignore it for the first wait cycle.
          if (wait_min && tbr) nxt = ST_IDLE;
        end
        default: nxt = ST_CFG_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_CFG_LO;
      armed <= 1'b0;
    end else begin
      state <= nxt;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_cfg  <= 2'b00;
      cfg_done <= 1'b0;
      wait_min <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      rx_valid <= 1'b0;
      wait_min <= (state == ST_TX_WAIT);
      if (state == ST_CFG_LO) cur_cfg <= br_cfg;
      if (armed && state == ST_CFG_HI) cfg_done <= 1'b1;
      if (armed && state == ST_IDLE && br_cfg != cur_cfg) cfg_done <= 1'b0;
      if (armed && state == ST_RX_READ) begin
        rx_valid <= 1'b1;
        rx_data  <= databus;
      end
    end
  end

endmodule

// File: tb/tb_spart_ctrl.sv
module tb_spart_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, rx_valid, cfg_done, iocs, iorw;
  logic [7:0] rx_data;
  logic [1:0] ioaddr;
  logic       rda, tbr;
  logic [7:0] rx_byte;
  wire  [7:0] databus;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // spart bus model: drives the RX buffer combinationally on reads.
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_byte : 8'hzz;

  spart_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .cfg_done (cfg_done),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rda      (rda),
    .tbr      (tbr)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] div_of(input logic [1:0] c);
    case (c)
      2'd0:    return 16'd10417;
      2'd1:    return 16'd5208;
      2'd2:    return 16'd2604;
      default: return 16'd1302;
    endcase
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [7:0] q[$];
  bit         pend_hi, pend_rx;
  logic [7:0] exp_rx;

  always @(negedge clk) begin
    logic [15:0] d;
    bit push_ok;
    if (!rst) begin
      q.delete();
      pend_hi = 0;
      pend_rx = 0;
    end else begin
      check("m_tx_ready", 32'(tx_ready), 32'(q.size() < 4));
      if (pend_rx) begin
        check("m_rx_valid", 32'(rx_valid), 32'd1);
        check("m_rx_data", 32'(rx_data), 32'(exp_rx));
        pend_rx = 0;
      end else begin
        check("m_rx_quiet", 32'(rx_valid), 32'd0);
      end
      push_ok = tx_valid && (q.size() < 4);
      d = div_of(br_cfg);
      if (iocs) begin
        if (iorw && ioaddr == 2'b00) begin
          pend_rx = 1;
          exp_rx  = rx_byte;
        end else if (!iorw && ioaddr == 2'b10) begin
          check("m_div_lo", 32'(databus), 32'(d[7:0]));
          pend_hi = 1;
        end else if (!iorw && ioaddr == 2'b11) begin
          check("m_div_order", 32'(pend_hi), 32'd1);
          check("m_div_hi", 32'(databus), 32'(d[15:8]));
          pend_hi = 0;
        end else if (!iorw && ioaddr == 2'b00) begin
          check("m_tx_nonempty", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            check("m_tx_data", 32'(databus), 32'(q[0]));
            void'(q.pop_front());
          end
          check("m_tx_cfg_done", 32'(cfg_done), 32'd1);
        end else begin
          check("m_bad_access", {29'd0, iorw, ioaddr}, 32'd0);
        end
      end
      if (push_ok) q.push_back(tx_data);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_access(input string nm, input logic rw, input logic [1:0] a,
                             input logic [7:0] dat, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (iocs) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no access within %0d cycles, expected rw=%0b addr=%0d data=%0h",
               nm, budget, rw, a, dat);
    end else begin
      check({nm, "_rw"},   32'(iorw),    32'(rw));
      check({nm, "_addr"}, 32'(ioaddr),  32'(a));
      check({nm, "_data"}, 32'(databus), 32'(dat));
    end
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_iocs"},     32'(iocs),     32'd0);
    check({nm, "_iorw"},     32'(iorw),     32'd1);
    check({nm, "_ioaddr"},   32'(ioaddr),   32'd0);
    check({nm, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({nm, "_rx_data"},  32'(rx_data),  32'd0);
    check({nm, "_cfg_done"}, 32'(cfg_done), 32'd0);
    check({nm, "_tx_ready"}, 32'(tx_ready), 32'd1);
  endtask

  task automatic expect_quiet(input string nm, input int cycles);
    bit seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (iocs) seen = 1;
    end
    check(nm, 32'(seen), 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0; br_cfg = 2'b01; tx_valid = 1'b0; tx_data = 8'h00;
    rda = 1'b0; tbr = 1'b1; rx_byte = 8'h00;
    #3 check_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // 1: divisor 5208 = 0x1458
    wait_access("t1_dbl", 1'b0, 2'b10, 8'h58, 3);
    check("t1_cfg_low", 32'(cfg_done), 32'd0);
    wait_access("t1_dbh", 1'b0, 2'b11, 8'h14, 1);
    @(negedge clk);
    check("t1_cfg_done", 32'(cfg_done), 32'd1);

    // 2: single TX byte, then TX_WAIT holds while tbr=0 (even with rda pending)
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h41;
    @(posedge clk); #1 tx_valid = 1'b0;
    wait_access("t2_wr", 1'b0, 2'b00, 8'h41, 4);
    tbr = 1'b0; rda = 1'b1; rx_byte = 8'h5A;
    expect_quiet("t2_hold", 5);
    tbr = 1'b1;

    // 3: RX read, pulse next cycle, then one idle bus cycle
    wait_access("t3_rd", 1'b1, 2'b00, 8'h5A, 3);
    rda = 1'b0;
    @(negedge clk);
    check("t3_pulse", 32'(rx_valid), 32'd1);
    check("t3_data",  32'(rx_data),  32'h5A);
    check("t3_idle",  32'(iocs),     32'd0);
    @(negedge clk);
    check("t3_pulse_end", 32'(rx_valid), 32'd0);

    // 4: rda and a buffered byte become eligible together -> read first
    tbr = 1'b0;
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h33;
    @(posedge clk); #1 tx_valid = 1'b0; rda = 1'b1; rx_byte = 8'hA7; tbr = 1'b1;
    wait_access("t4_rd", 1'b1, 2'b00, 8'hA7, 2);
    rda = 1'b0;
    wait_access("t4_wr", 1'b0, 2'b00, 8'h33, 4);
    tbr = 1'b0;

    // 5: fill the FIFO with tbr low; fifth byte is dropped
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'(i);
    end
    @(negedge clk);
    check("t5_full", 32'(tx_ready), 32'd0);
    @(posedge clk); #1 tx_valid = 1'b0;
    @(negedge clk);
    check("t5_still_full", 32'(tx_ready), 32'd0);
    tbr = 1'b1;
    for (int k = 1; k <= 4; k++)
      wait_access($sformatf("t5_wr%0d", k), 1'b0, 2'b00, 8'(k), 8);
    expect_quiet("t5_no_fifth", 10);
    check("t5_ready", 32'(tx_ready), 32'd1);

    // 6: reconfigure to 1302 = 0x0516, then reset in TX_WAIT
    @(posedge clk); #1 br_cfg = 2'b11;
    wait_access("t6_dbl", 1'b0, 2'b10, 8'h16, 3);
    check("t6_cfg_clr", 32'(cfg_done), 32'd0);
    wait_access("t6_dbh", 1'b0, 2'b11, 8'h05, 1);
    @(negedge clk);
    check("t6_cfg_done", 32'(cfg_done), 32'd1);
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h77;
    @(posedge clk); #1 tx_valid = 1'b0;
    wait_access("t6_wr", 1'b0, 2'b00, 8'h77, 4);
    tbr = 1'b0;
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h88;
    @(posedge clk); #1 tx_data = 8'h99;
    @(posedge clk); #1 tx_valid = 1'b0;
    rst = 1'b0;
    #1 check_reset("t6_rst");
    tbr = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    wait_access("t6_re_dbl", 1'b0, 2'b10, 8'h16, 3);
    wait_access("t6_re_dbh", 1'b0, 2'b11, 8'h05, 1);
    expect_quiet("t6_fifo_empty", 10);
    check("t6_ready", 32'(tx_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
